// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM state
// encoding, result-vector bit positions and the operand/digit legality rule.
package cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int R_GT = 0;
    localparam int R_EQ = 1;
    localparam int R_LT = 2;

    // Digits must be non-empty and tile the operand exactly.
    function automatic bit dims_legal(input int width, input int digit);
        return (digit > 0) && (width >= digit) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational DIGIT-bit magnitude comparator; msb_signed flips the top bit
// of both digits so a two's-complement sign digit orders correctly.
module cmp_digit
    import cmp_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             msb_signed,
    output logic             dgt,
    output logic             deq,
    output logic             dlt
);

    logic [DIGIT-1:0] flip_s;
    logic [DIGIT-1:0] xs_s;
    logic [DIGIT-1:0] ys_s;

    // Offset-binary adjustment followed by a plain unsigned compare.
    always_comb begin
        flip_s             = '0;
        flip_s[DIGIT-1]    = msb_signed;
        xs_s               = x ^ flip_s;
        ys_s               = y ^ flip_s;
        dgt                = (xs_s > ys_s);
        deq                = (xs_s == ys_s);
        dlt                = (xs_s < ys_s);
    end

endmodule

// File: rtl/seq_mag_comparator.sv
// Sequential MSB-first magnitude comparator: scans DIGIT bits per clock and
// stops at the first differing digit, reporting one-hot gt/eq/lt and depth.
module seq_mag_comparator
    import cmp_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DIGIT = 4,
    localparam int NDIG  = WIDTH / DIGIT,
    localparam int CW    = $clog2(NDIG + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CW-1:0]    digits
);

    localparam int PW = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;

    generate
        if (!dims_legal(WIDTH, DIGIT)) begin : g_bad_dims
            $error("seq_mag_comparator: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [2:0]       res_q, res_d;
    logic [CW-1:0]    digits_q, digits_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    logic [PW-1:0]    base_s;
    logic [DIGIT-1:0] da_s;
    logic [DIGIT-1:0] db_s;
    logic             msb_signed_s;
    logic             dgt_s, deq_s, dlt_s;

    // Digit index 0 is the most significant digit.
    always_comb begin
        base_s       = PW'((NDIG - 1 - int'(idx_q)) * DIGIT);
        da_s         = a_q[base_s +: DIGIT];
        db_s         = b_q[base_s +: DIGIT];
        msb_signed_s = sgn_q && (idx_q == CW'(0));
    end

    cmp_digit #(.DIGIT(DIGIT)) u_digit (
        .x          (da_s),
        .y          (db_s),
        .msb_signed (msb_signed_s),
        .dgt        (dgt_s),
        .deq        (deq_s),
        .dlt        (dlt_s)
    );

    // Next-state, operand capture and result update.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
        idx_d    = idx_q;
        res_d    = res_q;
        digits_d = digits_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = signed_mode;
                    idx_d   = CW'(0);
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!deq_s) begin
                    res_d       = 3'b000;
                    res_d[R_GT] = dgt_s;
                    res_d[R_LT] = dlt_s;
                    digits_d    = idx_q + CW'(1);
                    state_d     = ST_DONE;
                end else if (idx_q == CW'(NDIG - 1)) begin
                    res_d       = 3'b000;
                    res_d[R_EQ] = 1'b1;
                    digits_d    = CW'(NDIG);
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Handshake flags follow the next state so they are plain flops.
        ready_d = (state_d != ST_SCAN);
        done_d  = (state_d == ST_DONE);
    end

    // State, operand and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            idx_q    <= '0;
            res_q    <= 3'b000;
            digits_q <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
            idx_q    <= idx_d;
            res_q    <= res_d;
            digits_q <= digits_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign gt     = res_q[R_GT];
    assign eq     = res_q[R_EQ];
    assign lt     = res_q[R_LT];
    assign digits = digits_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Self-checking bench for seq_mag_comparator (WIDTH=16, DIGIT=4): directed
// scenarios plus random operands checked against an arithmetic reference.
module tb_seq_mag_comparator;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CW    = $clog2(NDIG + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             signed_mode = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             ready, done, gt, eq, lt;
    logic [CW-1:0]    digits;

    int total = 0;
    int bad   = 0;

    seq_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .ready       (ready),
        .done        (done),
        .gt          (gt),
        .eq          (eq),
        .lt          (lt),
        .digits      (digits)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: ordering from integer arithmetic, depth from the highest differing bit.
    task automatic model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic ts,
                         output logic egt, output logic eeq, output logic elt, output int edg);
        int sa, sb, p;
        logic [WIDTH-1:0] x;
        if (ts) begin
            sa = int'($signed(ta));
            sb = int'($signed(tb));
        end else begin
            sa = int'(ta);
            sb = int'(tb);
        end
        egt = (sa > sb);
        eeq = (sa == sb);
        elt = (sa < sb);
        x = ta ^ tb;
        p = -1;
        for (int i = 0; i < WIDTH; i++) if (x[i]) p = i;
        edg = (p < 0) ? NDIG : NDIG - (p / DIGIT);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},  {31'b0, ready}, 32'd1);
        check({tag, "_done"},   {31'b0, done},  32'd0);
        check({tag, "_flags"},  {29'b0, gt, eq, lt}, 32'd0);
        check({tag, "_digits"}, {{(32-CW){1'b0}}, digits}, 32'd0);
    endtask

    // Waits (bounded) for done at negedges; returns edges seen.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic ts);
        logic egt, eeq, elt;
        int   edg, n;
        model(ta, tb, ts, egt, eeq, elt, edg);
        @(negedge clk);
        check({tag, "_ready_idle"}, {31'b0, ready}, 32'd1);
        a = ta; b = tb; signed_mode = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); signed_mode = ~ts;
        check({tag, "_ready_scan"}, {31'b0, ready}, 32'd0);
        wait_done(n);
        check({tag, "_latency"}, 32'(n), 32'(edg));
        check({tag, "_flags"}, {29'b0, gt, eq, lt}, {29'b0, egt, eeq, elt});
        check({tag, "_digits"}, {{(32-CW){1'b0}}, digits}, 32'(edg));
        check({tag, "_ready_done"}, {31'b0, ready}, 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, ndone;
        logic cgt;
        logic [CW-1:0] cdig;

        // Reset held two cycles.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // Equal operands scan every digit.
        run_op("equal", 16'h1234, 16'h1234, 1'b0);
        check("equal_eq", {31'b0, eq}, 32'd1);

        // Reset mid-scan: no done pulse, outputs back to reset values.
        @(negedge clk);
        a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("midreset");
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("midreset_no_done", 32'(ndone), 32'd0);

        // MSB digit decides, unsigned then signed.
        run_op("msb_u", 16'h8000, 16'h7FFF, 1'b0);
        check("msb_u_gt", {31'b0, gt}, 32'd1);
        run_op("msb_s", 16'h8000, 16'h7FFF, 1'b1);
        check("msb_s_lt", {31'b0, lt}, 32'd1);

        // Third digit decides.
        run_op("mid", 16'h12A4, 16'h12B4, 1'b0);
        check("mid_lt", {31'b0, lt}, 32'd1);

        // Start during SCAN is ignored.
        @(negedge clk);
        a = 16'h0001; b = 16'h0000; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h0000; b = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; cgt = 1'b0; cdig = '0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) begin
                ndone++;
                cgt = gt;
                cdig = digits;
            end
            @(negedge clk);
        end
        check("ignored_ndone", 32'(ndone), 32'd1);
        check("ignored_gt", {31'b0, cgt}, 32'd1);
        check("ignored_digits", {{(32-CW){1'b0}}, cdig}, 32'd4);

        // Back-to-back: new start in the DONE cycle.
        @(negedge clk);
        a = 16'h12A4; b = 16'h12B4; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("b2b_first_done", {31'b0, done}, 32'd1);
        a = 16'hFFFF; b = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_gap_done", {31'b0, done}, 32'd0);
        check("b2b_prev_held", {29'b0, gt, eq, lt}, 32'd1);
        check("b2b_prev_digits", {{(32-CW){1'b0}}, digits}, 32'd3);
        @(negedge clk);
        check("b2b_second_done", {31'b0, done}, 32'd1);
        check("b2b_second_gt", {29'b0, gt, eq, lt}, 32'd4);
        check("b2b_second_digits", {{(32-CW){1'b0}}, digits}, 32'd1);
        @(negedge clk);

        // Random operands, often sharing leading digits.
        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] ra, rb;
            int sh;
            ra = WIDTH'($urandom);
            sh = $urandom_range(0, WIDTH);
            rb = (i % 4 == 0) ? ra : (ra ^ (WIDTH'($urandom) >> sh));
            if (i % 5 == 1) rb = WIDTH'($urandom);
            run_op("rand", ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_mag_comparator.md
# seq_mag_comparator

Parametrised, sequential magnitude comparator for the comparator family. It accepts two WIDTH-bit operands with a start/ready handshake and scans them MSB-first, DIGIT bits per clock. It stops at the first differing digit and returns one-hot greater/equal/less flags plus the number of digits scanned. Unlike the fixed 4-bit combinational ripple comparator, it supports arbitrary width, a selectable digit size, a signed mode and early termination.

## Interface
- WIDTH, 16: operand width in bits. Must be ≥ DIGIT.
- DIGIT, 4: bits compared per cycle. WIDTH % DIGIT == 0 is required; elaboration fails otherwise.
- NDIG (derived localparam): WIDTH/DIGIT.
- CW (derived localparam): $clog2(NDIG+1), the width of `digits`.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a comparison; accepted only when ready=1.
- signed_mode  in  1  1 = two's-complement compare; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- ready  out  1  high when a start can be accepted (states IDLE and DONE).
- done  out  1  one-cycle pulse when the result is written.
- gt  out  1  A > B.
- eq  out  1  A == B.
- lt  out  1  A < B.
- digits  out  CW  digits examined for the last result (1..NDIG).

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: ready=1. On start, latch a, b and signed_mode, clear the digit index, go to SCAN.
- SCAN: ready=0. Compare digit index j (j=0 is the MSB digit) of the latched operands.
  - If the digits differ, write gt/lt accordingly, set eq=0, set digits=j+1, go to DONE.
  - If the digits are equal and j==NDIG-1, write eq=1, set digits=NDIG, go to DONE.
  - Otherwise increment j and stay in SCAN.
- DONE: done=1 and ready=1 for exactly one cycle. Start in this cycle is accepted and goes to SCAN; otherwise go to IDLE.
- Signed mode: for digit j=0 only, invert the top bit of both digits before the unsigned compare (offset-binary trick). All other digits compare unsigned.
- Result holding: gt/eq/lt/digits keep the last result until the next result is written. They are not cleared on start.
- Exactly one of gt/eq/lt is 1 after the first done. All three are 0 from reset until the first done.
- Start with ready=0 (SCAN) is ignored; no queueing.
- Operand or signed_mode changes after acceptance have no effect.
- Reset values: state=IDLE, ready=1, done=0, gt=eq=lt=0, digits=0.
- Reset in any state, including mid-SCAN, aborts the operation: no done pulse, outputs return to reset values.

## Timing
- Cycle 0: start accepted (start=1 and ready=1 at the clock edge).
- Cycle j+1: SCAN examines digit j.
- Cycle k+2: done=1 with results valid, where k is the deciding digit. Results are registered, so there is no combinational path from a/b to the outputs.
- Latency: minimum 2 cycles (MSB digit differs), maximum NDIG+1 cycles (equal operands).
- Throughput: back-to-back operation is possible via start in the DONE cycle. The next done follows at least 2 cycles later.
- ready is a registered function of state. start has no combinational path to any output.

## Structure
- Package cmp_pkg holds:
  - state encoding localparams ST_IDLE, ST_SCAN, ST_DONE;
  - result-index constants R_GT, R_EQ, R_LT;
  - shared WIDTH/DIGIT legality checks.
- Sub-module cmp_digit: combinational DIGIT-bit comparator.
  - Inputs: x, y, msb_signed.
  - Outputs: dgt, deq, dlt.
  - Instantiated once; the top selects digit j with an indexed part-select.
- Top holds the FSM, operand registers, digit counter and result registers.

## Test plan
All scenarios use WIDTH=16, DIGIT=4.
- Reset: assert rst for 2 cycles → ready=1, done=0, gt=eq=lt=0, digits=0. Reset again mid-SCAN → no done, same reset values.
- Equal: a=b=16'h1234, unsigned → done exactly 5 cycles after start, eq=1, digits=4.
- MSB decides: a=16'h8000, b=16'h7FFF, signed_mode=0 → gt=1, digits=1, done at cycle 2. Repeat with signed_mode=1 → lt=1, digits=1.
- Mid-digit decides: a=16'h12A4, b=16'h12B4 → lt=1, digits=3, done at cycle 4.
- Ignored start: during SCAN of a=16'h0001, b=16'h0000, pulse start with a=b=0 → only one done, gt=1, digits=4.
- Back-to-back: hold start through the DONE cycle with new operands a=16'hFFFF, b=16'h0000 → accepted, second done 2 cycles later with gt=1. The previous result stays visible until then.
